// File: rtl/dispatch_arbiter.sv
// Four-way round-robin dispatcher feeding a shared 8-entry queue, with flush/drain control.
// Optional DISPATCH_ARB_FIXED_PRIO_EN gives requester 0 absolute priority; others rotate.
module dispatch_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    input  logic         flush,
    input  logic         fifo_read,
    output logic [3:0]   gnt,
    output logic         fifo_write,
    output logic [31:0]  fifo_wData,
    output logic [3:0]   occupancy,
    output logic         busy,
    output logic         drain_done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic       grant_ok;
    logic       found;
    logic       granted;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       read_ok;

    // Eligibility uses only registered occupancy, so a same-cycle read never frees a slot early.
    always_comb begin
        grant_ok = !rst && !flush && (state != DRAIN) && (occupancy != 4'd8) && (req != 4'b0000);
        gnt_idx  = rr_ptr;
        cand     = rr_ptr;
        found    = 1'b0;
`ifdef DISPATCH_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            gnt_idx = 2'd0;
            found   = 1'b1;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
        granted = grant_ok && found;
        gnt     = 4'b0000;
        if (granted) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign read_ok = fifo_read && (occupancy != 4'd0);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 2'd0;
            occupancy  <= 4'd0;
            fifo_write <= 1'b0;
            fifo_wData <= 32'd0;
            drain_done <= 1'b0;
        end else begin
            fifo_write <= granted;
            drain_done <= 1'b0;
            if (granted) begin
                fifo_wData <= req_data[{gnt_idx, 5'd0} +: 32];
`ifdef DISPATCH_ARB_FIXED_PRIO_EN
                if (gnt_idx != 2'd0) begin
                    rr_ptr <= gnt_idx + 2'd1;
                end
`else
                rr_ptr <= gnt_idx + 2'd1;
`endif
            end

            if (granted && !read_ok) begin
                occupancy <= occupancy + 4'd1;
            end else if (!granted && read_ok) begin
                occupancy <= occupancy - 4'd1;
            end

            // Drain exits only once the queue is empty and the last write has landed.
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (req != 4'b0000) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (req == 4'b0000 && occupancy == 4'd0) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (occupancy == 4'd0 && !fifo_write) begin
                        state      <= IDLE;
                        drain_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
